// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and load/store.
// One outstanding transaction, variable-latency ack, flush of in-flight fetches and bus timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  output logic        if_stall_req_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_sel_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        ls_stall_req_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUSY = 3'd1,
    LS_BUSY = 3'd2,
    IF_DROP = 3'd3,
    IF_DONE = 3'd4,
    LS_DONE = 3'd5
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_ls_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_sel_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       if_rdata_q;
  logic              if_err_q;
  logic [31:0]       ls_rdata_q;
  logic              ls_err_q;

  logic timeout_hit;
  logic grant_ls;
  logic grant_if;

  // A zero TIMEOUT_CYCLES disables the abort path entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // LS wins a tie unless it won the previous grant.
  assign grant_ls = ls_req_i && (!if_req_i || !last_ls_q);
  assign grant_if = if_req_i && !grant_ls;

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_ls_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      if_err_q    <= 1'b0;
      ls_rdata_q  <= 32'h0;
      ls_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grant_ls) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we_i;
            mem_sel_q   <= ls_sel_i;
            mem_addr_q  <= ls_addr_i;
            mem_wdata_q <= ls_wdata_i;
            last_ls_q   <= 1'b1;
            state_q     <= LS_BUSY;
          end else if (grant_if) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 4'hF;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= 32'h0;
            last_ls_q   <= 1'b0;
            state_q     <= IF_BUSY;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i || timeout_hit) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (flush_i) begin
              state_q <= IDLE;
            end else begin
              if_rdata_q <= mem_ack_i ? mem_rdata_i : 32'h0;
              if_err_q   <= !mem_ack_i;
              state_q    <= IF_DONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (flush_i) state_q <= IF_DROP;
          end
        end
        // Flushed fetch: let the bus finish, then throw the data away.
        IF_DROP: begin
          if (mem_ack_i || timeout_hit) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LS_BUSY: begin
          if (mem_ack_i || timeout_hit) begin
            mem_req_q  <= 1'b0;
            cnt_q      <= '0;
            ls_rdata_q <= mem_ack_i ? mem_rdata_i : 32'h0;
            ls_err_q   <= !mem_ack_i;
            state_q    <= LS_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IF_DONE: state_q <= IDLE;
        LS_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flush in IF_DONE withholds the completion, so the stall stays up.
  assign if_stall_req_o = if_req_i && !((state_q == IF_DONE) && !flush_i);
  assign ls_stall_req_o = ls_req_i && (state_q != LS_DONE);

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter with a 4-cycle bus timeout.
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        if_stall_req_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_sel_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [31:0] ls_rdata_o;
  logic        ls_err_o;
  logic        ls_stall_req_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_err_o(if_err_o), .if_stall_req_o(if_stall_req_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_sel_i(ls_sel_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_rdata_o(ls_rdata_o),
    .ls_err_o(ls_err_o), .ls_stall_req_o(ls_stall_req_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_rst_i = 1'b0; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_sel_i = 4'h0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tick(); tick();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_ls_err", ls_err_o, 0);
    check("rst_if_stall", if_stall_req_o, 0);
    n_rst_i = 1'b1;
    tick();

    // Zero-wait fetch
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000;
    #1 check("t1_stall_n", if_stall_req_o, 1);
    tick();
    check("t1_req", mem_req_o, 1);
    check("t1_addr", mem_addr_o, 32'h8000_0000);
    check("t1_we", mem_we_o, 0);
    check("t1_sel", mem_sel_o, 4'hF);
    check("t1_stall_n1", if_stall_req_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    tick();
    mem_ack_i = 1'b0;
    check("t1_stall_n2", if_stall_req_o, 0);
    check("t1_rdata", if_rdata_o, 32'h0000_0013);
    check("t1_req_drop", mem_req_o, 0);
    if_req_i = 1'b0;
    tick();

    // Concurrent IF + LS store, last grant was IF
    if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_sel_i = 4'b0011; ls_addr_i = 32'h1000; ls_wdata_i = 32'hDEAD_BEEF;
    tick();
    check("t2_ls_addr", mem_addr_o, 32'h1000);
    check("t2_ls_we", mem_we_o, 1);
    check("t2_ls_sel", mem_sel_o, 4'b0011);
    check("t2_ls_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0;
    tick();
    mem_ack_i = 1'b0;
    check("t2_ls_done_stall", ls_stall_req_o, 0);
    check("t2_if_wait_stall", if_stall_req_o, 1);
    tick();
    check("t2_idle_ls_stall", ls_stall_req_o, 1);
    tick();
    check("t2_if_addr", mem_addr_o, 32'h8000_0004);
    check("t2_if_we", mem_we_o, 0);
    check("t2_if_sel", mem_sel_o, 4'hF);
    ls_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0010_0093;
    tick();
    mem_ack_i = 1'b0;
    check("t2_if_rdata", if_rdata_o, 32'h0010_0093);
    check("t2_if_stall", if_stall_req_o, 0);
    if_req_i = 1'b0;
    tick();

    // 3-wait-state load
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_sel_i = 4'hF; ls_addr_i = 32'h2004;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_req_held", mem_req_o, 1);
      check("t3_addr_stable", mem_addr_o, 32'h2004);
      check("t3_stall_hi", ls_stall_req_o, 1);
      if (i == 3) begin
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      end
      tick();
    end
    mem_ack_i = 1'b0;
    check("t3_rdata", ls_rdata_o, 32'h1234_5678);
    check("t3_stall_lo", ls_stall_req_o, 0);
    check("t3_req_lo", mem_req_o, 0);
    tick();
    check("t3_stall_back", ls_stall_req_o, 1);
    ls_req_i = 1'b0;
    tick();

    // Flush during IF_BUSY
    if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
    tick();
    flush_i = 1'b1;
    check("t4_busy_req", mem_req_o, 1);
    tick();
    flush_i = 1'b0; if_addr_i = 32'h8000_0100;
    #1 check("t4_drop_req", mem_req_o, 1);
    check("t4_drop_addr", mem_addr_o, 32'h8000_0008);
    check("t4_drop_stall", if_stall_req_o, 1);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_AAAA;
    tick();
    mem_ack_i = 1'b0;
    check("t4_rdata_kept", if_rdata_o, 32'h0010_0093);
    check("t4_no_done_stall", if_stall_req_o, 1);
    check("t4_req_lo", mem_req_o, 0);
    tick();
    check("t4_new_addr", mem_addr_o, 32'h8000_0100);
    check("t4_new_req", mem_req_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0113;
    tick();
    mem_ack_i = 1'b0;
    check("t4_new_rdata", if_rdata_o, 32'h0000_0113);
    if_req_i = 1'b0;
    tick();

    // Flush in IF_DONE holds the stall
    if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0777;
    tick();
    mem_ack_i = 1'b0; flush_i = 1'b1;
    #1 check("t5_done_flush_stall", if_stall_req_o, 1);
    flush_i = 1'b0; if_req_i = 1'b0;
    tick();

    // Load timeout, then a successful load clears the error
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h3000;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t6_req_held", mem_req_o, 1);
      tick();
    end
    check("t6_req_lo", mem_req_o, 0);
    check("t6_err", ls_err_o, 1);
    check("t6_rdata0", ls_rdata_o, 0);
    check("t6_stall_rel", ls_stall_req_o, 0);
    ls_req_i = 1'b0;
    tick();
    ls_req_i = 1'b1; ls_addr_i = 32'h3004;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0055;
    tick();
    mem_ack_i = 1'b0;
    check("t6_err_clr", ls_err_o, 0);
    check("t6_rdata_ok", ls_rdata_o, 32'h0000_0055);
    ls_req_i = 1'b0;
    tick();

    // Reset in LS_BUSY
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_sel_i = 4'hF; ls_addr_i = 32'h4000; ls_wdata_i = 32'h1;
    tick();
    check("t7_busy", mem_req_o, 1);
    n_rst_i = 1'b0; ls_req_i = 1'b0;
    tick();
    check("t7_req", mem_req_o, 0);
    check("t7_addr", mem_addr_o, 0);
    check("t7_we", mem_we_o, 0);
    check("t7_ls_rdata", ls_rdata_o, 0);
    check("t7_if_rdata", if_rdata_o, 0);
    n_rst_i = 1'b1;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0200;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h5000;
    tick();
    check("t7_idle_grant_ls", mem_addr_o, 32'h5000);
    check("t7_idle_grant_we", mem_we_o, 0);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0;
    tick();
    mem_ack_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
